// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: stage occupancy states and ID/EX bundle layouts.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int IDEX_CTRL_W = 10;
  localparam int IDEX_DATA_W = 165;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
  } idex_data_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module pipe_sat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid buffer and flush.
// Optional stall/bubble counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              drain;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q & ~flush;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Entries are left in place; out_ctrl is masked and out_data keeps its last value.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_cnt u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed handshake/flush/reset steps then random traffic,
// all checked against a capacity-two FIFO reference model.
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 165;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
  logic [31:0]   stall_exp;
  logic [31:0]   bubble_exp;
`endif

  beat_t         mq[$];
  logic [DW-1:0] shown_data;
  int            checks = 0;
  int            errors = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs follow from the FIFO contents: head drives the outputs, capacity is two.
  task automatic checkOutput(input string tag);
    logic [CW-1:0] exp_ctrl;
    exp_ctrl = (mq.size() > 0) ? mq[0].ctrl : '0;
    checkEq({tag, ".out_valid"}, {191'd0, out_valid}, {191'd0, mq.size() > 0});
    checkEq({tag, ".in_ready"},  {191'd0, in_ready},  {191'd0, mq.size() < 2});
    checkEq({tag, ".out_ctrl"},  192'(out_ctrl), 192'(exp_ctrl));
    checkEq({tag, ".out_data"},  192'(out_data), 192'(shown_data));
`ifdef PIPE_STAGE_PERF_EN
    checkEq({tag, ".stall_cnt"},  192'(stall_cnt),  192'(stall_exp));
    checkEq({tag, ".bubble_cnt"}, 192'(bubble_cnt), 192'(bubble_exp));
`endif
  endtask

  task automatic modelReset();
    mq.delete();
    shown_data = '0;
`ifdef PIPE_STAGE_PERF_EN
    stall_exp  = '0;
    bubble_exp = '0;
`endif
  endtask

  // Drive one beat of inputs, advance one clock, update the model, land on the next negedge.
  task automatic applyStimulus(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy, input logic fl);
    beat_t b;
    logic  acc, drn;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (mq.size() < 2) && !fl;
    drn = (mq.size() > 0) && ordy;
`ifdef PIPE_STAGE_PERF_EN
    if (mq.size() > 0 && !ordy && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
    if (mq.size() == 0 && bubble_exp != 32'hFFFF_FFFF) bubble_exp = bubble_exp + 1;
`endif
    @(posedge clk);
    if (drn) b = mq.pop_front();
    if (fl) mq.delete();
    else if (acc) begin
      b.ctrl = c;
      b.data = d;
      mq.push_back(b);
    end
    if (mq.size() > 0) shown_data = mq[0].data;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    checkEq("reset.in_ready_one", {191'd0, in_ready}, 192'd1);
    reset = 1'b0;

    // Streaming at full rate.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, CW'(k), rand_data(), 1'b1, 1'b0);
      checkOutput("stream");
      checkEq("stream.ctrl_const", 192'(out_ctrl), 192'(k));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stream_drain");

    // Skid: two beats with downstream stalled.
    applyStimulus(1'b1, CW'('h11), rand_data(), 1'b0, 1'b0);
    checkOutput("skid_a");
    applyStimulus(1'b1, CW'('h22), rand_data(), 1'b0, 1'b0);
    checkOutput("skid_b");
    checkEq("skid.full_ready", {191'd0, in_ready}, 192'd0);
    checkEq("skid.hold_a", 192'(out_ctrl), 192'h11);
    applyStimulus(1'b1, CW'('h2F), rand_data(), 1'b0, 1'b0);
    checkOutput("skid_hold");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("skid_out_b");
    checkEq("skid.then_b", 192'(out_ctrl), 192'h22);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("skid_empty");

    // Flush while full, with a live input beat that must vanish.
    applyStimulus(1'b1, CW'('h31), rand_data(), 1'b0, 1'b0);
    applyStimulus(1'b1, CW'('h32), rand_data(), 1'b0, 1'b0);
    checkOutput("flush_full");
    applyStimulus(1'b1, CW'('h33), rand_data(), 1'b0, 1'b1);
    checkOutput("flush_two");
    checkEq("flush.ctrl_zero", 192'(out_ctrl), 192'd0);
    applyStimulus(1'b1, CW'('h44), rand_data(), 1'b0, 1'b0);
    checkOutput("flush_d");
    checkEq("flush.d_next", 192'(out_ctrl), 192'h44);

    // Flush together with a drain from ONE.
    applyStimulus(1'b1, CW'('h55), rand_data(), 1'b1, 1'b1);
    checkOutput("flush_drain");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    checkOutput("flush_empty_noop");

    // Asynchronous reset in the middle of a cycle with a beat held.
    applyStimulus(1'b1, CW'('h66), rand_data(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    modelReset();
    #1 checkOutput("async_reset");
    checkEq("async_reset.data_zero", 192'(out_data), 192'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    applyStimulus(1'b1, CW'('h77), rand_data(), 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("perf_stall");
    checkEq("perf.stall7", 192'(stall_cnt), 192'd7);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 4) != 0, CW'($urandom), rand_data(),
                    ($urandom % 3) != 0, ($urandom % 16) == 0);
      checkOutput("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
